// File: rtl/and_or_verif_pkg.sv
// rtl/and_or_verif_pkg.sv - shared types, constants and golden model for AND_OR verification
package and_or_verif_pkg;

  localparam int VEC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic and_or_model(input logic [VEC_W-1:0] v);
    return (v[0] & v[1]) | (v[2] & v[3]);
  endfunction

endpackage

// File: rtl/and_or_stall_timer.sv
// rtl/and_or_stall_timer.sv - counts idle cycles and flags the cycle the stall limit is reached
module and_or_stall_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fires on the idle cycle whose increment makes the count reach TIMEOUT.
  assign expired = en & ~clr & (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/and_or_resp_checker.sv
// rtl/and_or_resp_checker.sv - checks AND_OR responses over a 4-bit sweep and reports a verdict
module and_or_resp_checker
  import and_or_verif_pkg::*;
#(
  parameter int NUM_VECTORS = 16,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stim_valid,
  input  logic [VEC_W-1:0] stim_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             seq_err,
  output logic             timeout,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam int IDX_W = VEC_W + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   exp_idx_q, exp_idx_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               seq_err_q, seq_err_d;
  logic               timeout_q, timeout_d;
  logic               ff_valid_q, ff_valid_d;
  logic [VEC_W-1:0]   ff_vec_q, ff_vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic arm;
  logic accept;
  logic expired;
  logic mismatch;
  logic last_vec;

  assign arm      = start & (state_q != RUN);
  assign accept   = stim_valid & (state_q == RUN);
  assign mismatch = dut_out != and_or_model(stim_in);
  assign last_vec = exp_idx_q == IDX_W'(NUM_VECTORS - 1);

  and_or_stall_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_stall_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (arm | accept),
    .en     ((state_q == RUN) & ~stim_valid),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    err_count_d = err_count_q;
    seq_err_d   = seq_err_q;
    timeout_d   = timeout_q;
    ff_valid_d  = ff_valid_q;
    ff_vec_d    = ff_vec_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          exp_idx_d   = '0;
          err_count_d = '0;
          seq_err_d   = 1'b0;
          timeout_d   = 1'b0;
          ff_valid_d  = 1'b0;
          ff_vec_d    = '0;
        end
      end
      RUN: begin
        if (stim_valid) begin
          if (mismatch) begin
            err_count_d = err_count_q + CNT_W'(1);
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_vec_d   = stim_in;
            end
          end
          // Order is flagged but the check still grades the vector actually received.
          if (stim_in != exp_idx_q[VEC_W-1:0]) begin
            seq_err_d = 1'b1;
          end
          exp_idx_d = exp_idx_q + IDX_W'(1);
          if (last_vec) begin
            state_d = DONE;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = state_d == RUN;
    done_d = state_d == DONE;
    pass_d = done_d & (err_count_d == '0) & ~seq_err_d & ~timeout_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_idx_q   <= '0;
      err_count_q <= '0;
      seq_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      ff_valid_q  <= 1'b0;
      ff_vec_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      err_count_q <= err_count_d;
      seq_err_q   <= seq_err_d;
      timeout_q   <= timeout_d;
      ff_valid_q  <= ff_valid_d;
      ff_vec_q    <= ff_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign seq_err          = seq_err_q;
  assign timeout          = timeout_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_and_or_resp_checker.sv
// tb/tb_and_or_resp_checker.sv - scoreboard bench for the AND_OR response checker
module tb_and_or_resp_checker;

  localparam int TMO = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stim_valid = 1'b0;
  logic [3:0] stim_in = '0;
  logic       dut_out = 1'b0;
  logic       busy, done, pass, seq_err, timeout, first_fail_valid;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic done_d1 = 1'b0;

  typedef struct {
    logic       pass;
    logic [4:0] err;
    logic       seq;
    logic       to;
    logic       ffv;
    logic [3:0] ffvec;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  and_or_resp_checker #(
    .NUM_VECTORS(16),
    .TIMEOUT    (TMO),
    .CNT_W      (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stim_valid      (stim_valid),
    .stim_in         (stim_in),
    .dut_out         (dut_out),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .seq_err         (seq_err),
    .timeout         (timeout),
    .first_fail_valid(first_fail_valid),
    .first_fail_vec  (first_fail_vec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-derived truth table: outputs high for vectors 3,7,11,12,13,14,15.
  function automatic logic gold(input logic [3:0] v);
    logic [15:0] t;
    t = 16'hF888;
    return t[v];
  endfunction

  always @(negedge clk) begin
    if (done && !done_d1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", busy, 0);
        chk("pass", pass, e.pass);
        chk("err_count", err_count, e.err);
        chk("seq_err", seq_err, e.seq);
        chk("timeout", timeout, e.to);
        chk("first_fail_valid", first_fail_valid, e.ffv);
        chk("first_fail_vec", first_fail_vec, e.ffvec);
      end
    end
    done_d1 <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [3:0] vec, input logic r);
    start      = s;
    stim_valid = v;
    stim_in    = vec;
    dut_out    = r;
    tick();
    start      = 1'b0;
    stim_valid = 1'b0;
  endtask

  task automatic push(input logic p, input logic [4:0] e, input logic sq, input logic to,
                      input logic fv, input logic [3:0] fvec, input int c);
    exp_t x;
    x.pass = p; x.err = e; x.seq = sq; x.to = to; x.ffv = fv; x.ffvec = fvec; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    chk(name, done, 1);
    tick();
  endtask

  task automatic run_sweep(input logic [15:0] flip, input bit swap56, input bit gaps, output int k);
    logic [3:0] v;
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      if (swap56 && i == 5) v = 4'd6;
      if (swap56 && i == 6) v = 4'd5;
      drive(1'b0, 1'b1, v, gold(v) ^ flip[v]);
      if (gaps && i < 15) drive(i == 8, 1'b0, 4'd0, 1'b0);
    end
    k = cyc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_ff_valid"}, first_fail_valid, 0);
    chk({tag, "_ff_vec"}, first_fail_vec, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

    // Clean sweep.
    run_sweep(16'h0000, 1'b0, 1'b0, k);
    push(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, k);
    wait_done("clean_done", 4);

    // Single fault at 0111, restarted from DONE.
    run_sweep(16'h0080, 1'b0, 1'b0, k);
    push(1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 4'b0111, k);
    wait_done("fault_done", 4);

    // Two faults; only the first one is captured.
    run_sweep(16'h0208, 1'b0, 1'b0, k);
    push(1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 4'd3, k);
    wait_done("fault2_done", 4);

    // Vectors 5 and 6 swapped, responses correct.
    run_sweep(16'h0000, 1'b1, 1'b0, k);
    push(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0, k);
    wait_done("order_done", 4);

    // Stall after three vectors.
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'(i), gold(4'(i)));
    k = cyc;
    push(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'd0, k + TMO);
    wait_done("stall_done", TMO + 4);

    // Gaps plus an ignored mid-run start.
    run_sweep(16'h0000, 1'b0, 1'b1, k);
    push(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, k);
    wait_done("gaps_done", 4);

    // Reset mid-sweep, then stimulus in IDLE must be ignored.
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 4'(i), gold(4'(i)) ^ (i == 2));
    chk("mid_err_count", err_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'd3, 1'b0);
    chk_zero("idle_stim");
    run_sweep(16'h0000, 1'b0, 1'b0, k);
    push(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, k);
    wait_done("post_rst_done", 4);

    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
